// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander: loads 16 words, then streams W[0..63] from a 16-word sliding window.
// Define SHA256_SCHED_LAST_EN to add the out_last port flagging W[63].
module sha256_msg_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_idx,
`ifdef SHA256_SCHED_LAST_EN
  output logic        out_last,
`endif
  output logic        busy
);

  typedef enum logic {LOAD = 1'b0, STREAM = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [15:0][31:0] w_q, w_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [31:0]       w_next;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // w[i] holds W[t+i], so W[t+16] needs w[14], w[9], w[1], w[0]
  assign w_next = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          w_d   = {in_data, w_q[15:1]};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd15) begin
            cnt_d   = '0;
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        // words appended past t=47 are never emitted; shifting anyway keeps the path uniform
        if (out_ready) begin
          w_d   = {w_next, w_q[15:1]};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) begin
            cnt_d   = '0;
            state_d = LOAD;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign out_data  = w_q[0];
  assign out_idx   = cnt_q;
`ifdef SHA256_SCHED_LAST_EN
  assign out_last  = out_valid & (cnt_q == 6'd63);
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched: driver pushes the reference schedule, a negedge monitor pops and compares.
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic        busy;
`ifdef SHA256_SCHED_LAST_EN
  logic        out_last;
`endif

  sha256_msg_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
`ifdef SHA256_SCHED_LAST_EN
    .out_last  (out_last),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [5:0]  idx_q[$];
  logic [31:0] blk [16];
  bit          abc_flag = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h", nm, act, exp);
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  // Full 64-entry reference schedule, pushed to the scoreboard
  task automatic push_block();
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = blk[t];
    for (int t = 16; t < 64; t++) w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      exp_q.push_back(w[t]);
      idx_q.push_back(6'(t));
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic set_pat(input logic [31:0] seed);
    for (int i = 0; i < 16; i++) blk[i] = (32'(i) * 32'h9E3779B9) ^ seed;
  endtask

  task automatic load_words(input int n, input bit gaps, input bit hold);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 1)) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = blk[i];
      @(negedge clk);
      chk("in_ready_load", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = hold;
    in_data  = $urandom;
  endtask

  task automatic load_block(input bit is_abc, input bit gaps, input bit hold);
    abc_flag = is_abc;
    push_block();
    load_words(16, gaps, hold);
    chk("first_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic stream_n(input int n, input int stall_pct, input bit hold);
    int hs  = 0;
    int cyc = 0;
    while (hs < n && cyc < 2000) begin
      out_ready = ($urandom_range(0, 99) >= stall_pct);
      if (hold) begin
        in_valid = 1'b1;
        in_data  = $urandom;
      end
      @(negedge clk);
      if (out_valid && out_ready) hs++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_handshakes", 32'(hs), 32'(n));
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (n == 64) begin
      chk("in_ready_after_stream", 32'(in_ready), 32'd1);
      chk("busy_after_stream", 32'(busy), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef SHA256_SCHED_LAST_EN
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
`endif
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    exp_q.delete();
    idx_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: handshakes pop the scoreboard; stalls must hold data/idx; valid may not drop mid-block
  bit          mid_stream = 1'b0;
  bit          stalled    = 1'b0;
  logic [31:0] held_d;
  logic [5:0]  held_i;
  logic [31:0] e;
  logic [5:0]  ei;

  always @(negedge clk) begin
    if (!rst_n) begin
      mid_stream = 1'b0;
      stalled    = 1'b0;
    end else if (out_valid) begin
      if (stalled) begin
        chk("stall_data", out_data, held_d);
        chk("stall_idx", 32'(out_idx), 32'(held_i));
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_empty: got W idx %0d data %08h, want none", out_idx, out_data);
        end else begin
          e  = exp_q.pop_front();
          ei = idx_q.pop_front();
          chk("out_data", out_data, e);
          chk("out_idx", 32'(out_idx), 32'(ei));
          chk("in_ready_in_stream", 32'(in_ready), 32'd0);
          chk("busy_in_stream", 32'(busy), 32'd1);
          if (abc_flag && ei == 6'd16) chk("abc_w16", out_data, 32'h61626380);
          if (abc_flag && ei == 6'd17) chk("abc_w17", out_data, 32'h000F0000);
          if (abc_flag && ei == 6'd63) chk("abc_w63", out_data, 32'h12B1EDEB);
`ifdef SHA256_SCHED_LAST_EN
          chk("out_last", 32'(out_last), 32'(ei == 6'd63));
`endif
        end
        stalled    = 1'b0;
        mid_stream = (out_idx != 6'd63);
      end else begin
        stalled = 1'b1;
        held_d  = out_data;
        held_i  = out_idx;
      end
    end else if (mid_stream) begin
      chk("valid_drop", 32'(out_valid), 32'd1);
      mid_stream = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    #1 check_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "abc" block, no stalls
    set_abc();
    load_block(1'b1, 1'b0, 1'b0);
    stream_n(64, 0, 1'b0);

    // all-zero block
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    load_block(1'b0, 1'b0, 1'b0);
    stream_n(64, 0, 1'b0);

    // "abc" with random backpressure and input bubbles
    set_abc();
    load_block(1'b1, 1'b1, 1'b0);
    stream_n(64, 50, 1'b0);

    // in_valid held through stream, then back-to-back next block
    set_pat(32'hDEADBEEF);
    load_block(1'b0, 1'b0, 1'b1);
    stream_n(64, 0, 1'b1);
    set_pat(32'h0BADF00D);
    load_block(1'b0, 1'b0, 1'b0);
    stream_n(64, 20, 1'b0);

    // reset at t=30 of stream, then fresh "abc"
    set_abc();
    load_block(1'b1, 1'b0, 1'b0);
    stream_n(30, 0, 1'b0);
    pulse_reset("mid_stream_reset");
    set_abc();
    load_block(1'b1, 1'b0, 1'b0);
    stream_n(64, 0, 1'b0);

    // reset after 9 loaded words, then a different full block
    set_pat(32'h12345678);
    abc_flag = 1'b0;
    load_words(9, 1'b0, 1'b0);
    pulse_reset("mid_load_reset");
    set_pat(32'hCAFEF00D);
    load_block(1'b0, 1'b0, 1'b0);
    stream_n(64, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
# sha256_msg_sched

SHA-256 message-schedule expander for the miner datapath. Accepts one 512-bit block as 16 serial 32-bit words, then streams the 64 schedule words W[0..63] one per handshake to the compression round stage. It consumes the existing rotr rotator to build the σ0 and σ1 functions. It holds a 16-word sliding window and needs no 64-word storage.

## Interface
- No parameters. Word width is fixed at 32 and round count at 64.
- Clock and reset: one clock, `clk`, rising edge. Reset `rst_n` is asynchronous and active-low.
- `clk` input, 1: clock.
- `rst_n` input, 1: async active-low reset.
- `in_valid` input, 1: `in_data` valid.
- `in_ready` output, 1: block is in LOAD and can accept a word.
- `in_data` input, 32: message word, M[0] first, big-endian word order.
- `out_valid` output, 1: `out_data` holds W[`out_idx`].
- `out_ready` input, 1: downstream accepts.
- `out_data` output, 32: schedule word.
- `out_idx` output, 6: index t of `out_data`, 0..63.
- `busy` output, 1: high in STREAM.

## Operation
- State is a 16×32 window w[0..15] (w[0] oldest), a 6-bit counter `cnt`, and state LOAD/STREAM.
- LOAD:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid & in_ready`: shift window left, w[15] ← `in_data`, cnt++.
  - On the 16th accepted word: cnt ← 0, go to STREAM.
- STREAM:
  - `in_ready`=0, `out_valid`=1, `out_data`=w[0], `out_idx`=cnt.
  - On `out_valid & out_ready`: shift left, w[15] ← σ1(w[14]) + w[9] + σ0(w[1]) + w[0], cnt++.
  - On the handshake with cnt=63: cnt ← 0, go to LOAD.
  - Words appended after t=47 are never emitted. They are don't-care, but the shift continues unconditionally.
- Functions:
  - σ0(x) = rotr(x,7) ^ rotr(x,18) ^ (x>>3).
  - σ1(x) = rotr(x,17) ^ rotr(x,19) ^ (x>>10).
- All addition is modulo 2^32. Carries beyond bit 31 are discarded.
- Invariant: during STREAM at index t, w[i] = W[t+i].
- `in_valid` during STREAM is ignored. No word is consumed.
- `out_ready` during LOAD is ignored.
- Reset values: window all 0, cnt=0, state LOAD. Outputs: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_idx`=0, `busy`=0.
- Reset mid-LOAD or mid-STREAM: immediate abort to the reset state. Partial block is discarded.

## Timing
- All outputs are driven from registers. `out_data` is w[0] directly, with no combinational path from inputs to outputs.
- The σ/adder path (three 32-bit adds) is the critical path and must close in one cycle.
- Load takes 16 handshake cycles minimum.
- First `out_valid` is asserted the cycle after the 16th input handshake.
- Stream takes 64 cycles minimum at `out_ready`=1. Minimum block period is 80 cycles.
- `in_ready` rises the cycle after the W[63] handshake. There is no overlap of load and stream.
- Backpressure: `out_ready`=0 holds w, cnt and `out_data` stable. `out_valid` stays high and never drops mid-stream.
- Input stalls: `in_valid`=0 holds state and cnt.

## Configuration
- Macro: `SHA256_SCHED_LAST_EN`.
- Defined: adds output port `out_last` (1 bit).
  - `out_last` = `out_valid` & (cnt==63). Reset value 0.
- Undefined: the port does not exist. All other behaviour is identical.

## Test plan
- "abc" padded block: W0=0x61626380, W1..W14=0, W15=0x00000018.
  - Expect W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB.
  - Expect `out_idx` 0..63 in order.
  - With the macro defined, expect `out_last` only at t=63.
- All-zero block: expect all 64 `out_data`=0, then `in_ready`=1 on the next cycle.
- Random `out_ready` (~50% duty) on the "abc" block:
  - Sequence is identical to the unstalled run.
  - `out_data`/`out_idx` are stable while stalled and `out_valid` never drops.
- `in_valid` held high through STREAM with changing `in_data`:
  - Outputs are unaffected.
  - The first word after stream end is accepted as M[0] of the next block.
  - Back-to-back blocks give correct results for both.
- Assert `rst_n`=0 at t=30 of STREAM:
  - Outputs take reset values asynchronously.
  - After release, a fresh "abc" load produces the correct W sequence.
- Reset after 9 loaded words, then load a full block: output matches the reference model for the new block only.
